// File: rtl/hex_display_ctrl.sv
// Registered front-panel output stage: bus LEDs, hex data digits (bus or register),
// timestep digit, blinking DONE LED, display freeze and optional leading-zero blanking.
//
// blink state | meaning
// BLK_IDLE    | DONE low (or just raised); LED_D off, counter cleared
// BLK_RUN     | DONE high; counter counts down, LED_D inverts at terminal count
module hex_display_ctrl #(
  parameter int DATA_W    = 10,
  parameter int NDIG      = 3,
  parameter int TIME_W    = 2,
  parameter int BLINK_DIV = 25000000,
  parameter int BLANK_LZ  = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DATA_W-1:0]   BUS,
  input  logic [DATA_W-1:0]   REG,
  input  logic [TIME_W-1:0]   TIME,
  input  logic                PEEKb,
  input  logic                DONE,
  input  logic                FREEZE,
  output logic [DATA_W-1:0]   LED_B,
  output logic [NDIG*7-1:0]   DHEX,
  output logic [6:0]          THEX,
  output logic                LED_D,
  output logic                FROZEN
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BLINK_DIV - 1);

  typedef enum logic {BLK_IDLE, BLK_RUN} blink_state_t;

  blink_state_t       blink_state;
  logic [CNT_W-1:0]   blink_cnt;
  logic [DATA_W-1:0]  dv;
  logic [DATA_W-1:0]  dv_nxt;
  logic [NDIG*4-1:0]  dv_ext;
  logic [NDIG*7-1:0]  dhex_nxt;
  logic [6:0]         thex_nxt;
  logic               freeze_q;
  logic               freeze_rise;
  logic               seen_nz;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign freeze_rise = FREEZE & ~freeze_q;

  // Digits are decoded from the next display value so DHEX lands on the same edge as DV.
  always_comb begin
    dv_nxt   = RST ? '0 : (FROZEN ? dv : (PEEKb ? BUS : REG));
    dv_ext   = '0;
    dv_ext[DATA_W-1:0] = dv_nxt;
    dhex_nxt = '0;
    seen_nz  = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      seen_nz = seen_nz | (dv_ext[4*i +: 4] != 4'h0);
      if ((BLANK_LZ != 0) && (i > 0) && !seen_nz)
        dhex_nxt[7*i +: 7] = 7'h7F;
      else
        dhex_nxt[7*i +: 7] = seg7(dv_ext[4*i +: 4]);
    end
    thex_nxt = RST ? 7'h40 : seg7(4'(TIME));
  end

  always_ff @(posedge CLK) begin
    freeze_q <= FREEZE;
    dv       <= dv_nxt;
    DHEX     <= dhex_nxt;
    THEX     <= thex_nxt;
    if (RST) begin
      LED_B       <= '0;
      FROZEN      <= 1'b0;
      LED_D       <= 1'b0;
      blink_cnt   <= '0;
      blink_state <= BLK_IDLE;
    end else begin
      LED_B  <= BUS;
      FROZEN <= FROZEN ^ freeze_rise;
      if (!DONE) begin
        LED_D       <= 1'b0;
        blink_cnt   <= '0;
        blink_state <= BLK_IDLE;
      end else begin
        case (blink_state)
          BLK_IDLE: begin
            LED_D       <= 1'b1;
            blink_cnt   <= CNT_TOP;
            blink_state <= BLK_RUN;
          end
          default: begin
            if (blink_cnt == '0) begin
              blink_cnt <= CNT_TOP;
              LED_D     <= ~LED_D;
            end else begin
              blink_cnt <= blink_cnt - 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: two instances (plain digits / blink div 3,
// and leading-zero blanking / blink div 1) driven from shared stimulus.
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        rst, peekb, done, freeze;
  logic [9:0]  bus, reg_v;
  logic [1:0]  time_v;

  logic [9:0]  led_b0, led_b1;
  logic [20:0] dhex0, dhex1;
  logic [6:0]  thex0, thex1;
  logic        led_d0, led_d1, frozen0, frozen1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    logic [20:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];

  localparam int S_LEDB0 = 0, S_DHEX0 = 1, S_THEX0 = 2, S_LEDD0 = 3,
                 S_FROZ0 = 4, S_DHEX1 = 5, S_LEDD1 = 6;

  hex_display_ctrl #(.DATA_W(10), .NDIG(3), .TIME_W(2), .BLINK_DIV(3), .BLANK_LZ(0)) dut0 (
    .CLK(clk), .RST(rst), .BUS(bus), .REG(reg_v), .TIME(time_v), .PEEKb(peekb),
    .DONE(done), .FREEZE(freeze), .LED_B(led_b0), .DHEX(dhex0), .THEX(thex0),
    .LED_D(led_d0), .FROZEN(frozen0));

  hex_display_ctrl #(.DATA_W(10), .NDIG(3), .TIME_W(2), .BLINK_DIV(1), .BLANK_LZ(1)) dut1 (
    .CLK(clk), .RST(rst), .BUS(bus), .REG(reg_v), .TIME(time_v), .PEEKb(peekb),
    .DONE(done), .FREEZE(freeze), .LED_B(led_b1), .DHEX(dhex1), .THEX(thex1),
    .LED_D(led_d1), .FROZEN(frozen1));

  always #5 clk = ~clk;

  function automatic logic [20:0] obs(input int sel);
    logic [20:0] v;
    case (sel)
      S_LEDB0: v = {11'd0, led_b0};
      S_DHEX0: v = dhex0;
      S_THEX0: v = {14'd0, thex0};
      S_LEDD0: v = {20'd0, led_d0};
      S_FROZ0: v = {20'd0, frozen0};
      S_DHEX1: v = dhex1;
      default: v = {20'd0, led_d1};
    endcase
    return v;
  endfunction

  function automatic logic [20:0] dh(input logic [6:0] d2, input logic [6:0] d1,
                                     input logic [6:0] d0);
    return {d2, d1, d0};
  endfunction

  task automatic expect_out(input int sel, input logic [20:0] val, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance one edge, then retire every expectation queued for it.
  task automatic tick();
    exp_t        e;
    logic [20:0] o;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bus = 10'h3A5; reg_v = 10'h000; time_v = 2'd0;
    peekb = 1'b1; done = 1'b0; freeze = 1'b0;

    // reset and latency
    expect_out(S_LEDB0, 21'h0, "rst_ledb");
    expect_out(S_DHEX0, dh(7'h40, 7'h40, 7'h40), "rst_dhex0");
    expect_out(S_DHEX1, dh(7'h7F, 7'h7F, 7'h40), "rst_dhex1");
    expect_out(S_THEX0, 21'h40, "rst_thex");
    expect_out(S_FROZ0, 21'h0, "rst_frozen");
    expect_out(S_LEDD0, 21'h0, "rst_ledd");
    tick();
    expect_out(S_DHEX0, dh(7'h40, 7'h40, 7'h40), "rst2_dhex0");
    expect_out(S_LEDB0, 21'h0, "rst2_ledb");
    tick();
    rst = 1'b0; time_v = 2'd2;
    expect_out(S_LEDB0, 21'h3A5, "rel_ledb");
    expect_out(S_DHEX0, dh(7'h30, 7'h08, 7'h12), "rel_dhex0");
    expect_out(S_DHEX1, dh(7'h30, 7'h08, 7'h12), "rel_dhex1");
    expect_out(S_THEX0, 21'h24, "rel_thex");
    tick();

    // source select
    reg_v = 10'h0F0; bus = 10'h001;
    expect_out(S_DHEX0, dh(7'h40, 7'h40, 7'h79), "sel_bus_dhex0");
    expect_out(S_DHEX1, dh(7'h7F, 7'h7F, 7'h79), "sel_bus_dhex1");
    expect_out(S_LEDB0, 21'h001, "sel_bus_ledb");
    tick();
    peekb = 1'b0;
    expect_out(S_DHEX0, dh(7'h40, 7'h0E, 7'h40), "sel_reg_dhex0");
    expect_out(S_DHEX1, dh(7'h7F, 7'h0E, 7'h40), "sel_reg_dhex1");
    expect_out(S_LEDB0, 21'h001, "sel_reg_ledb");
    tick();

    // freeze
    bus = 10'h123; peekb = 1'b1; freeze = 1'b1;
    expect_out(S_FROZ0, 21'h1, "frz_set");
    expect_out(S_DHEX0, dh(7'h79, 7'h24, 7'h30), "frz_capture");
    tick();
    freeze = 1'b0; bus = 10'h2FF;
    expect_out(S_DHEX0, dh(7'h79, 7'h24, 7'h30), "frz_hold");
    expect_out(S_LEDB0, 21'h2FF, "frz_ledb");
    expect_out(S_FROZ0, 21'h1, "frz_still");
    tick();
    peekb = 1'b0;
    expect_out(S_DHEX0, dh(7'h79, 7'h24, 7'h30), "frz_peek_ignored");
    tick();
    peekb = 1'b1; freeze = 1'b1;
    expect_out(S_FROZ0, 21'h0, "unfrz_clear");
    expect_out(S_DHEX0, dh(7'h79, 7'h24, 7'h30), "unfrz_noload");
    tick();
    freeze = 1'b0;
    expect_out(S_DHEX0, dh(7'h24, 7'h0E, 7'h0E), "unfrz_resume");
    tick();
    freeze = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_out(S_FROZ0, 21'h1, "frz_level_once");
      tick();
    end
    freeze = 1'b0;
    expect_out(S_FROZ0, 21'h1, "frz_level_release");
    tick();
    freeze = 1'b1;
    expect_out(S_FROZ0, 21'h0, "frz_unfreeze2");
    tick();
    freeze = 1'b0;

    // leading-zero blanking sweep
    bus = 10'h000;
    expect_out(S_DHEX1, dh(7'h7F, 7'h7F, 7'h40), "blank_000");
    expect_out(S_DHEX0, dh(7'h40, 7'h40, 7'h40), "noblank_000");
    tick();
    bus = 10'h00A;
    expect_out(S_DHEX1, dh(7'h7F, 7'h7F, 7'h08), "blank_00A");
    expect_out(S_DHEX0, dh(7'h40, 7'h40, 7'h08), "noblank_00A");
    tick();
    bus = 10'h050;
    expect_out(S_DHEX1, dh(7'h7F, 7'h12, 7'h40), "blank_050");
    tick();
    bus = 10'h200;
    expect_out(S_DHEX1, dh(7'h24, 7'h40, 7'h40), "blank_200");
    tick();

    // blink: div 3 on dut0, div 1 on dut1
    done = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      expect_out(S_LEDD0, (k <= 3 || k >= 7) ? 21'h1 : 21'h0, $sformatf("blink3_c%0d", k));
      expect_out(S_LEDD1, (k % 2 == 1) ? 21'h1 : 21'h0, $sformatf("blink1_c%0d", k));
      tick();
    end
    done = 1'b0;
    expect_out(S_LEDD0, 21'h0, "blink3_drop");
    expect_out(S_LEDD1, 21'h0, "blink1_drop");
    tick();

    // mid-operation reset
    freeze = 1'b1;
    expect_out(S_FROZ0, 21'h1, "mid_frozen");
    tick();
    done = 1'b1;
    expect_out(S_LEDD0, 21'h1, "mid_blink_on");
    tick();
    time_v = 2'd3;
    expect_out(S_THEX0, 21'h30, "mid_thex3");
    tick();
    rst = 1'b1;
    expect_out(S_LEDB0, 21'h0, "mrst_ledb");
    expect_out(S_DHEX0, dh(7'h40, 7'h40, 7'h40), "mrst_dhex0");
    expect_out(S_DHEX1, dh(7'h7F, 7'h7F, 7'h40), "mrst_dhex1");
    expect_out(S_THEX0, 21'h40, "mrst_thex");
    expect_out(S_LEDD0, 21'h0, "mrst_ledd");
    expect_out(S_FROZ0, 21'h0, "mrst_frozen");
    tick();
    rst = 1'b0; bus = 10'h155;
    expect_out(S_FROZ0, 21'h0, "mrel_no_toggle");
    expect_out(S_LEDB0, 21'h155, "mrel_ledb");
    expect_out(S_DHEX0, dh(7'h79, 7'h12, 7'h12), "mrel_dhex0");
    expect_out(S_LEDD0, 21'h1, "mrel_ledd");
    tick();
    expect_out(S_FROZ0, 21'h0, "mrel_no_toggle2");
    tick();
    freeze = 1'b0;
    tick();
    freeze = 1'b1;
    expect_out(S_FROZ0, 21'h1, "mrel_edge_ok");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
